// File: rtl/stream_matcher.sv
// stream_matcher: sliding-window symbol pattern detector; holds a match until acked and flags stream end
module stream_matcher #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N*W-1:0] pattern,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    input  logic           in_last,
    output logic           in_ready,
    output logic           matched,
    input  logic           match_ack,
    output logic           stop,
    output logic [CW-1:0]  sym_count
);
    localparam int FW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t         state, state_n;
    logic [N*W-1:0] win, win_n, pat_r;
    logic [FW-1:0]  fill, fill_n;
    logic           last_pend;
    logic           xfer, arm, hit;

    assign xfer   = state == RUN && in_valid;
    assign arm    = start && (state == IDLE || state == DONE);
    assign win_n  = {win[N*W-W-1:0], in_data};
    assign fill_n = fill == FW'(N) ? fill : fill + 1'b1;
    // fill guards against matching a pattern of zeros against the cleared window
    assign hit    = win_n == pat_r && fill_n == FW'(N);

    assign in_ready = state == RUN;
    assign matched  = state == HOLD;
    assign stop     = state == DONE;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = start ? RUN : IDLE;
            RUN:  state_n = !in_valid ? RUN : hit ? HOLD : in_last ? DONE : RUN;
            HOLD: state_n = !match_ack ? HOLD : last_pend ? DONE : RUN;
            DONE: state_n = start ? RUN : DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || arm) begin
            pat_r     <= reset ? '0 : pattern;
            win       <= '0;
            fill      <= '0;
            sym_count <= '0;
            last_pend <= 1'b0;
        end else if (xfer) begin
            win       <= win_n;
            fill      <= fill_n;
            sym_count <= &sym_count ? sym_count : sym_count + 1'b1;
            if (hit) last_pend <= in_last;
        end
    end
endmodule

// File: tb/tb_stream_matcher.sv
// tb_stream_matcher: randomized scoreboard bench; a queue model predicts match/stop events
module tb_stream_matcher;
    logic        clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0;
    logic [31:0] pattern = '0;
    logic [7:0]  in_data = '0;
    logic        in_ready, matched, stop, match_ack, ack_auto = 0, ack_force = 0;
    logic [15:0] sym_count;

    assign match_ack = ack_auto | ack_force;

    stream_matcher dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .matched(matched), .match_ack(match_ack),
        .stop(stop), .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    typedef struct {bit is_stop; int cnt;} ev_t;
    ev_t        exp_q[$];
    logic [7:0] syms[$];
    int         n_chk = 0, n_fail = 0, xfer_count = 0, ack_dly = 0;
    bit         mon_en = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: invariants every cycle, and pops the scoreboard on each matched/stop rise
    initial begin
        bit pm = 0, ps = 0;
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check(!(matched && in_ready), "ready_in_hold", int'(in_ready), 0);
                check(!(matched && stop), "stop_with_match", int'(stop), 0);
                check(int'(sym_count) == (xfer_count > 65535 ? 65535 : xfer_count),
                      "sym_count_track", int'(sym_count), xfer_count);
                if ((matched && !pm) || (stop && !ps)) begin
                    if (exp_q.size() == 0) begin
                        check(0, "unexpected_event", int'(stop), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check(e.is_stop == stop, "event_kind", int'(stop), int'(e.is_stop));
                        check(int'(sym_count) == e.cnt, "event_count", int'(sym_count), e.cnt);
                    end
                end
            end
            pm = matched;
            ps = stop;
        end
    end

    // Acknowledger: pulses match_ack ack_dly cycles after matched rises, abandons if it drops
    initial forever begin
        @(posedge clk); #1;
        if (matched) begin
            int k = 0;
            while (k < ack_dly && matched) begin
                @(posedge clk); #1;
                k++;
            end
            if (matched) begin
                ack_auto = 1;
                @(posedge clk); #1;
                ack_auto = 0;
            end
        end
    end

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        xfer_count = 0;
    endtask

    // Plays syms[] as one stream; abort leaves the final stop unpredicted and does not wait for it
    task automatic run_stream(input logic [31:0] pat, input int vprob, input int adly,
                              input bit ctl, input bit abort);
        logic [7:0] w[$];
        int n = syms.size(), cnt = 0, i = 0, guard = 0, k = 0;
        bit go, pulsed = 0;
        ack_dly = adly;
        for (int j = 0; j < n; j++) begin
            w.push_back(syms[j]);
            if (w.size() > 4) void'(w.pop_front());
            cnt = cnt < 65535 ? cnt + 1 : cnt;
            if (w.size() == 4 && {w[0], w[1], w[2], w[3]} == pat) exp_q.push_back('{0, cnt});
            if (j == n - 1 && !abort) exp_q.push_back('{1, cnt});
        end
        start = 1;
        pattern = pat;
        @(posedge clk); #1;
        start = 0;
        xfer_count = 0;
        pattern = $urandom;
        check(in_ready == 1, "ready_after_start", int'(in_ready), 1);
        while (i < n && guard < n * 20 + 100) begin
            in_valid = $urandom_range(99) < vprob;
            in_data  = in_valid ? syms[i] : 8'($urandom);
            in_last  = in_valid ? (i == n - 1) : 1'($urandom);
            if (ctl && i == 2 && !pulsed) begin
                start = 1;
                ack_force = 1;
                pulsed = 1;
            end
            go = in_valid && in_ready;
            @(posedge clk); #1;
            start = 0;
            ack_force = 0;
            if (go) begin
                i++;
                xfer_count++;
            end
            guard++;
        end
        in_valid = 0;
        in_last = 0;
        check(i == n, "stream_accepted", i, n);
        if (!abort) begin
            while (!stop && k < 500) begin
                @(posedge clk); #1;
                k++;
            end
            check(stop == 1, "stop_reached", int'(stop), 1);
            @(negedge clk); #1;
            check(exp_q.size() == 0, "events_drained", exp_q.size(), 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic set_syms(input logic [31:0] a, input int n);
        syms.delete();
        for (int j = 0; j < n; j++) syms.push_back(a[31-8*(j%4) -: 8]);
    endtask

    initial begin
        int k;
        @(posedge clk); #1;
        do_reset();
        check(in_ready == 0 && matched == 0 && stop == 0, "reset_flags",
              {in_ready, matched, stop}, 0);
        check(sym_count == 0, "reset_count", int'(sym_count), 0);
        mon_en = 1;

        set_syms(32'h41424344, 4);
        run_stream(32'h41424344, 100, 0, 0, 0);
        check(sym_count == 4, "basic_count", int'(sym_count), 4);

        set_syms(32'h41414141, 6);
        run_stream(32'h41414141, 100, 2, 0, 0);
        check(sym_count == 6, "overlap_count", int'(sym_count), 6);

        do_reset();
        set_syms(32'h00000000, 3);
        run_stream(32'h00000000, 100, 0, 0, 0);
        set_syms(32'h41424345, 4);
        run_stream(32'h00000000, 100, 0, 0, 0);
        check(sym_count == 4, "near_miss_count", int'(sym_count), 4);
        set_syms(32'h41424345, 4);
        run_stream(32'h41424344, 100, 0, 0, 0);

        set_syms(32'h41424344, 8);
        run_stream(32'h41424344, 50, 5, 0, 0);

        set_syms(32'h41424344, 8);
        run_stream(32'h41424344, 100, 1, 1, 0);

        set_syms(32'h41424344, 4);
        run_stream(32'h41424344, 100, 50, 0, 1);
        k = 0;
        while (!matched && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check(matched == 1, "hold_reached", int'(matched), 1);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check(matched == 0 && in_ready == 0 && stop == 0, "midhold_reset_flags",
              {matched, in_ready, stop}, 0);
        check(sym_count == 0, "midhold_reset_count", int'(sym_count), 0);
        check(exp_q.size() == 0, "midhold_events", exp_q.size(), 0);
        set_syms(32'h55667788, 6);
        run_stream(32'h77885566, 70, 0, 0, 0);

        for (int t = 0; t < 6; t++) begin
            logic [31:0] p;
            int n = $urandom_range(8, 30);
            for (int j = 0; j < 4; j++) p[8*j +: 8] = $urandom_range(1) ? 8'h41 : 8'h42;
            syms.delete();
            for (int j = 0; j < n; j++) syms.push_back($urandom_range(1) ? 8'h41 : 8'h42);
            run_stream(p, $urandom_range(40, 100), $urandom_range(4), 1, 0);
        end

        syms.delete();
        for (int j = 0; j < 65537; j++) syms.push_back(8'h00);
        run_stream(32'h41424344, 100, 0, 0, 0);
        check(sym_count == 16'hFFFF, "saturate", int'(sym_count), 65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_matcher.md
# stream_matcher

Upstream pattern-detection stage for the match-counting controller. Consumes a stream of symbols over a valid/ready handshake and keeps a sliding window of the last N symbols. Raises `matched` when the window equals a loaded pattern and holds it until the downstream controller acknowledges. Raises `stop` once the final symbol of the stream has been fully processed.

## Interface
- `W`, 8, symbol width in bits
- `N`, 4, pattern length in symbols (N ≥ 2)
- `CW`, 16, width of the accepted-symbol counter
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clock clk
- `start`  in  1  arms the block and latches `pattern`; honoured only in IDLE or DONE
- `pattern`  in  N*W  target sequence; oldest symbol in bits [N*W-1 -: W], newest in [W-1:0]
- `in_valid`  in  1  upstream symbol valid
- `in_data`  in  W  symbol
- `in_last`  in  1  qualifies the final symbol of the stream
- `in_ready`  out  1  block can accept a symbol this cycle
- `matched`  out  1  window equals pattern; held until acknowledged
- `match_ack`  in  1  downstream consumed the match
- `stop`  out  1  stream exhausted, no match pending
- `sym_count`  out  CW  symbols accepted since last `start`, saturating

## Operation
- A transfer occurs when `in_valid && in_ready`.
- States:
  - IDLE: `in_ready`=0. `start` → RUN.
  - RUN: `in_ready`=1.
  - HOLD: `in_ready`=0, `matched`=1.
  - DONE: `in_ready`=0, `stop`=1. `start` → RUN.
- On `start`:
  - latch `pattern` into internal `pat_r`
  - clear window, `fill`, `sym_count` and `last_pend`
- On a transfer in RUN:
  - window shifts left by W; `in_data` enters the low W bits and the oldest symbol is dropped.
  - `fill` increments, saturating at N.
  - `sym_count` increments, saturating at 2^CW−1.
- Hit: the post-shift window equals `pat_r` and the post-increment `fill` equals N.
- RUN transitions on a transfer:
  - hit → HOLD; `last_pend` = `in_last`.
  - no hit and `in_last` → DONE.
  - otherwise stay in RUN.
- HOLD: `match_ack` → DONE if `last_pend`, else RUN. Window and `fill` are unchanged, so overlapping matches are detected (pattern 41414141, six 0x41 symbols → three matches).
- `match_ack` is ignored outside HOLD. `start` is ignored in RUN and HOLD.
- `in_data` and `in_last` are ignored when no transfer occurs.
- `pattern` changes after `start` have no effect until the next `start`.
- Reset in any state, including mid-stream or in HOLD:
  - state → IDLE
  - window, `fill`, `pat_r`, `last_pend` and `sym_count` cleared
  - any pending match is discarded

## Timing
- Reset values: `in_ready`=0, `matched`=0, `stop`=0, `sym_count`=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- `start` at edge k puts the block in RUN; `in_ready`=1 from cycle k+1.
- Match latency: the completing symbol transfers at edge t. At edge t, state → HOLD, so `matched`=1 and `in_ready`=0 during cycle t+1.
- `matched` stays high through the cycle in which `match_ack` is sampled.
  - `matched` and `in_ready` change the cycle after that edge.
  - Minimum HOLD duration is 1 cycle (ack already high on entry).
- Final symbol without a hit transfers at edge t → `stop`=1 from cycle t+1.
- Final symbol with a hit transfers at edge t → `matched`=1 from cycle t+1. `stop`=1 the cycle after `match_ack` is sampled. `stop` and `matched` are never high together.
- `sym_count` reflects a transfer in the cycle following that transfer.
- Throughput: 1 symbol/cycle in RUN. At least 1 bubble per match.

## Test plan
- Reset then `start`, pattern 0x41424344, stream 41,42,43,44 (last on 44), `match_ack` high when `matched` rises:
  - `matched` rises the cycle after 44 transfers and clears 1 cycle later
  - `stop`=1 the cycle after the ack
  - `sym_count`=4
- Overlap: pattern 0x41414141, stream 41×6 (last on the 6th), ack 2 cycles after each `matched` rise:
  - exactly 3 matches
  - `in_ready` low during each HOLD
  - `stop` after the 3rd ack
  - `sym_count`=6
- Underfill and near miss: pattern 0x00000000 after reset, stream 00,00,00 (last) → no `matched`, `stop`=1. Then `start`, stream 41,42,43,45 (last) → no `matched`, `stop`=1, `sym_count`=4.
- Backpressure and gaps: pattern 0x41424344, stream 41,42,43,44,41,42,43,44 (last on the final 44), `in_valid` toggling randomly, `match_ack` delayed 5 cycles:
  - 2 matches
  - no symbol lost or duplicated while `in_ready`=0
  - `in_data` changes during stalls are ignored
- Reset mid-HOLD: assert `reset` 2 cycles into a pending match → next cycle `matched`=0, `in_ready`=0, `stop`=0, `sym_count`=0. Then `start` with a new pattern → fresh detection works.
- Control ignores: `start` pulsed in RUN and `match_ack` pulsed in RUN → no state change, `sym_count` unaffected. `sym_count` saturates at 0xFFFF with CW=16 under a long stream.
